// File: rtl/smpl_queue_pkg.sv
// Shared types, default sizing and pointer-wrap helper for the sample window queue.
package smpl_queue_pkg;

    typedef enum logic {WRITE, READ} state_t;

    localparam int unsigned SQ_DW    = 16;
    localparam int unsigned SQ_NCH   = 2;
    localparam int unsigned SQ_DEPTH = 1536;
    localparam int unsigned SQ_TAPS  = 1021;

    // Ring increment by compare, so DEPTH need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/smpl_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module smpl_dpram #(
    parameter  int unsigned DEPTH = 1536,
    parameter  int unsigned W     = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/smpl_window_queue.sv
// Circular sample queue: each write after the window is primed streams the last TAPS samples, oldest first.
// Build option: define SMPL_QUEUE_HOLD_EN to buffer one sample that arrives during a burst.
module smpl_window_queue
    import smpl_queue_pkg::*;
#(
    parameter int unsigned DW    = SQ_DW,
    parameter int unsigned NCH   = SQ_NCH,
    parameter int unsigned DEPTH = SQ_DEPTH,
    parameter int unsigned TAPS  = SQ_TAPS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrt_smpl,
    input  logic [NCH*DW-1:0] smpl_in,
    input  logic              flush,
    output logic [NCH*DW-1:0] smpl_out,
    output logic              sequencing,
    output logic              full,
    output logic              ovr
);

    localparam int unsigned W  = NCH * DW;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(TAPS + 1);
    localparam logic [PW:0] BACK_X = (PW + 1)'(TAPS - 1);
    localparam logic [PW:0] WRAP_X = (PW + 1)'(DEPTH);

    state_t        state_q, state_d;
    logic [PW-1:0] new_ptr_q, new_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic          ovr_q, ovr_d;
    logic          seq_q, seq_d;
`ifdef SMPL_QUEUE_HOLD_EN
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_v_q, hold_v_d;
`endif

    logic          wr_req;
    logic          ram_we, ram_re;
    logic [W-1:0]  ram_wdata, ram_rdata;
    logic [PW:0]   back_x;
    logic [PW-1:0] win_start;

    // Oldest window address: one bit wider so underflow shows in the MSB.
    assign back_x    = {1'b0, new_ptr_q} - BACK_X;
    assign win_start = back_x[PW] ? PW'(back_x + WRAP_X) : back_x[PW-1:0];

    always_comb begin
        state_d   = state_q;
        new_ptr_d = new_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        bcnt_d    = bcnt_q;
        ovr_d     = ovr_q;
        seq_d     = 1'b0;
        wr_req    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_wdata = smpl_in;
`ifdef SMPL_QUEUE_HOLD_EN
        hold_d    = hold_q;
        hold_v_d  = hold_v_q;
`endif
        if (flush) begin
            state_d   = WRITE;
            new_ptr_d = '0;
            cnt_d     = '0;
            bcnt_d    = '0;
            ovr_d     = 1'b0;
`ifdef SMPL_QUEUE_HOLD_EN
            hold_v_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                WRITE: begin
`ifdef SMPL_QUEUE_HOLD_EN
                    wr_req = hold_v_q | wrt_smpl;
                    // A held sample goes first; a coincident strobe takes its place in the hold.
                    if (hold_v_q) begin
                        ram_wdata = hold_q;
                        hold_v_d  = wrt_smpl;
                        if (wrt_smpl) hold_d = smpl_in;
                    end
`else
                    wr_req = wrt_smpl;
`endif
                    if (wr_req) begin
                        ram_we    = 1'b1;
                        new_ptr_d = PW'(wrap_inc(32'(new_ptr_q), DEPTH));
                        if (cnt_q != CW'(TAPS)) cnt_d = cnt_q + CW'(1);
                        if (cnt_q >= CW'(TAPS - 1)) begin
                            rd_ptr_d = win_start;
                            bcnt_d   = '0;
                            state_d  = READ;
                        end
                    end
                end
                READ: begin
                    ram_re   = 1'b1;
                    seq_d    = 1'b1;
                    rd_ptr_d = PW'(wrap_inc(32'(rd_ptr_q), DEPTH));
                    bcnt_d   = bcnt_q + CW'(1);
                    if (bcnt_q == CW'(TAPS - 1)) state_d = WRITE;
                    if (wrt_smpl) begin
`ifdef SMPL_QUEUE_HOLD_EN
                        if (hold_v_q) begin
                            ovr_d = 1'b1;
                        end else begin
                            hold_d   = smpl_in;
                            hold_v_d = 1'b1;
                        end
`else
                        ovr_d = 1'b1;
`endif
                    end
                end
                default: state_d = WRITE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WRITE;
            new_ptr_q <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            ovr_q     <= 1'b0;
            seq_q     <= 1'b0;
`ifdef SMPL_QUEUE_HOLD_EN
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            new_ptr_q <= new_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            ovr_q     <= ovr_d;
            seq_q     <= seq_d;
`ifdef SMPL_QUEUE_HOLD_EN
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
`endif
        end
    end

    smpl_dpram #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (new_ptr_q),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign smpl_out   = seq_q ? ram_rdata : '0;
    assign sequencing = seq_q;
    assign full       = (cnt_q == CW'(TAPS));
    assign ovr        = ovr_q;

endmodule

// File: tb/tb_smpl_window_queue.sv
// Directed bench for smpl_window_queue: small instance (TAPS=8, DEPTH=12) plus a default-sized instance.
module tb_smpl_window_queue;

    localparam int unsigned TAPS  = 8;
    localparam int unsigned DEPTH = 12;

    typedef struct {
        logic [15:0] val;
        bit          burst;
        logic [15:0] first;
        bit          full_after;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        wrt_smpl;
    logic [31:0] smpl_in;
    logic        flush;
    logic [31:0] smpl_out;
    logic        sequencing;
    logic        full;
    logic        ovr;

    logic        d_wrt;
    logic [31:0] d_in;
    logic        d_flush;
    logic [31:0] d_out;
    logic        d_seq;
    logic        d_full;
    logic        d_ovr;

    int n_chk;
    int n_fail;
    int cyc;
    logic [15:0] got[$];
    int          got_t[$];
    logic [15:0] exp_q[$];
    int          exp_t[$];
    vec_t        tbl[30];

    smpl_window_queue #(
        .DW    (16),
        .NCH   (2),
        .DEPTH (DEPTH),
        .TAPS  (TAPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (wrt_smpl),
        .smpl_in    (smpl_in),
        .flush      (flush),
        .smpl_out   (smpl_out),
        .sequencing (sequencing),
        .full       (full),
        .ovr        (ovr)
    );

    smpl_window_queue u_def (
        .clk        (clk),
        .rst_n      (rst_n),
        .wrt_smpl   (d_wrt),
        .smpl_in    (d_in),
        .flush      (d_flush),
        .smpl_out   (d_out),
        .sequencing (d_seq),
        .full       (d_full),
        .ovr        (d_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_log();
        got.delete();
        got_t.delete();
        exp_q.delete();
        exp_t.delete();
        cyc = 0;
    endtask

    task automatic wr(input logic [15:0] v);
        wrt_smpl = 1'b1;
        smpl_in  = {~v, v};
    endtask

    task automatic step();
        logic [15:0] m;
        @(posedge clk);
        #1;
        wrt_smpl = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        cyc++;
        if (sequencing) begin
            got.push_back(smpl_out[15:0]);
            got_t.push_back(cyc);
            m = ~smpl_out[15:0];
            chk("ch1_mirror", smpl_out[31:16], m);
        end else begin
            chk("idle_out_zero", smpl_out, 0);
        end
    endtask

    task automatic expect_run(input int first, input int n, input int t0);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(16'(first + k));
            exp_t.push_back(t0 + k);
        end
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({name, "_val"}, got[i], exp_q[i]);
            chk({name, "_cycle"}, got_t[i], exp_t[i]);
        end
    endtask

    task automatic run_vec(input vec_t t);
        string nm;
        nm = $sformatf("smpl%0d", t.val);
        clr_log();
        wr(t.val);
        repeat (10) step();
        if (t.burst) expect_run(int'(t.first), TAPS, 2);
        check_log(nm);
        chk({nm, "_full"}, full, t.full_after);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [15:0] d_first, d_last;
        int d_first_t;

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        wrt_smpl = 1'b0;
        smpl_in = '0;
        flush = 1'b0;
        d_wrt = 1'b0;
        d_in = '0;
        d_flush = 1'b0;

        for (int i = 0; i < 30; i++)
            tbl[i] = '{val: 16'(i + 1), burst: (i + 1) >= 8, first: 16'(i + 1 - 7), full_after: (i + 1) >= 8};

        repeat (3) @(negedge clk);
        chk("rst_seq", sequencing, 0);
        chk("rst_out", smpl_out, 0);
        chk("rst_full", full, 0);
        chk("rst_ovr", ovr, 0);
        rst_n = 1'b1;
        clr_log();
        repeat (2) step();

        // Fill and stream across the pointer wrap
        for (int i = 0; i < 30; i++) run_vec(tbl[i]);
        chk("table_ovr", ovr, 0);

        // Overrun: sample 9 lands three cycles into the burst of 1..8
        flush = 1'b1;
        step();
        chk("idle_flush_full", full, 0);
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);
        clr_log();
        wr(16'd8);
        repeat (3) step();
        wr(16'd9);
        repeat (17) step();
        expect_run(1, TAPS, 2);
`ifdef SMPL_QUEUE_HOLD_EN
        expect_run(2, TAPS, 11);
        chk("ovr_hold", ovr, 0);
`else
        chk("ovr_drop", ovr, 1);
`endif
        check_log("ovr_burst");
        clr_log();
        wr(16'd10);
        repeat (10) step();
`ifdef SMPL_QUEUE_HOLD_EN
        expect_run(3, TAPS, 2);
        chk("ovr_hold_after", ovr, 0);
`else
        expect_run(2, TAPS - 1, 2);
        exp_q.push_back(16'd10);
        exp_t.push_back(9);
        chk("ovr_sticky", ovr, 1);
`endif
        check_log("after_ovr");

        // Flush in the fourth cycle of a burst
        clr_log();
        wr(16'd11);
        repeat (4) step();
        flush = 1'b1;
        step();
        chk("flush_seq", sequencing, 0);
        chk("flush_full", full, 0);
        chk("flush_ovr", ovr, 0);
        repeat (10) step();
`ifdef SMPL_QUEUE_HOLD_EN
        expect_run(4, 3, 2);
`else
        expect_run(3, 3, 2);
`endif
        check_log("flush_abort");
        for (int v = 100; v < 108; v++)
            run_vec('{val: 16'(v), burst: v == 107, first: 16'd100, full_after: v == 107});

        // Async reset in the middle of a burst with overrun pending
        clr_log();
        wr(16'd108);
        repeat (3) step();
        wr(16'd200);
        step();
        wr(16'd201);
        step();
        chk("pre_rst_ovr", ovr, 1);
        chk("pre_rst_seq", sequencing, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seq", sequencing, 0);
        chk("mid_rst_out", smpl_out, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovr", ovr, 0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Default-sized instance: 1021 back-to-back writes, one full window burst
        for (int v = 1; v <= 1021; v++) begin
            d_wrt = 1'b1;
            d_in  = {~16'(v), 16'(v)};
            if (v == 1021) chk("def_full_before", d_full, 0);
            @(posedge clk);
            #1;
        end
        d_wrt = 1'b0;
        cnt = 0;
        d_first = '0;
        d_last = '0;
        d_first_t = 0;
        for (int i = 1; i <= 1040; i++) begin
            @(negedge clk);
            if (d_seq) begin
                cnt++;
                if (cnt == 1) begin
                    d_first = d_out[15:0];
                    d_first_t = i;
                end
                d_last = d_out[15:0];
            end
        end
        chk("def_burst_len", cnt, 1021);
        chk("def_first_val", d_first, 1);
        chk("def_last_val", d_last, 1021);
        chk("def_first_cycle", d_first_t, 2);
        chk("def_full", d_full, 1);
        chk("def_ovr", d_ovr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
